// File: rtl/tmr_mismatch_monitor_if.sv
// Bundle between a triplicated register stage, the mismatch monitor and fault management.
// Carries the replica samples, voted result, error status and the fault-report handshake.
interface tmr_mismatch_monitor_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] rep_0;
  logic [WIDTH-1:0] rep_1;
  logic [WIDTH-1:0] rep_2;
  logic             clr;
  logic             out_valid;
  logic [WIDTH-1:0] voted_out;
  logic [2:0]       mis_vec;
  logic             uncorr;
  logic [CNT_W-1:0] err_cnt_0;
  logic [CNT_W-1:0] err_cnt_1;
  logic [CNT_W-1:0] err_cnt_2;
  logic [2:0]       fault_flag;
  logic             rpt_valid;
  logic [1:0]       rpt_idx;
  logic             rpt_ready;

  modport master (
    output in_valid, rep_0, rep_1, rep_2, clr, rpt_ready,
    input  out_valid, voted_out, mis_vec, uncorr, err_cnt_0, err_cnt_1, err_cnt_2,
           fault_flag, rpt_valid, rpt_idx
  );

  modport slave (
    input  in_valid, rep_0, rep_1, rep_2, clr, rpt_ready,
    output out_valid, voted_out, mis_vec, uncorr, err_cnt_0, err_cnt_1, err_cnt_2,
           fault_flag, rpt_valid, rpt_idx
  );
endinterface

// File: rtl/tmr_mismatch_monitor.sv
// TMR monitor: registered 2-of-3 vote, per-replica error counters and persistence FSMs, sticky
// fault flags. Define TMR_MON_REPORT_EN to build the pending-report arbiter.
module tmr_mismatch_monitor #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PERSIST = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  tmr_mismatch_monitor_if.slave bus
);

  typedef enum logic [1:0] {StOk, StSuspect, StFaulty} rep_state_e;

  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [3:0]       PersistN = 4'(PERSIST);

  logic [WIDTH-1:0] maj;
  logic [2:0]       mis;
  logic             uncorr_d;

  assign maj      = (bus.rep_0 & bus.rep_1) | (bus.rep_1 & bus.rep_2) | (bus.rep_2 & bus.rep_0);
  assign mis[0]   = bus.in_valid && (bus.rep_0 != maj);
  assign mis[1]   = bus.in_valid && (bus.rep_1 != maj);
  assign mis[2]   = bus.in_valid && (bus.rep_2 != maj);
  assign uncorr_d = (mis[0] & mis[1]) | (mis[1] & mis[2]) | (mis[2] & mis[0]);

  logic             out_valid_q;
  logic [WIDTH-1:0] voted_q;
  logic [2:0]       mis_q;
  logic             uncorr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      voted_q     <= '0;
      mis_q       <= '0;
      uncorr_q    <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      mis_q       <= mis;
      uncorr_q    <= uncorr_d;
      if (bus.in_valid) voted_q <= maj;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.voted_out = voted_q;
  assign bus.mis_vec   = mis_q;
  assign bus.uncorr    = uncorr_q;

  rep_state_e       state_q [3];
  rep_state_e       state_d [3];
  logic [3:0]       run_q   [3];
  logic [3:0]       run_d   [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [CNT_W-1:0] cnt_d   [3];
  logic [2:0]       flag_q;
  logic [2:0]       flag_d;
  logic [2:0]       enter;

  always_comb begin
    enter = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      run_d[i]   = run_q[i];
      cnt_d[i]   = cnt_q[i];
      if (mis[i]) begin
        if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + 1'b1;
        case (state_q[i])
          StOk: begin
            if (PersistN == 4'd1) begin
              state_d[i] = StFaulty;
              enter[i]   = 1'b1;
            end else begin
              state_d[i] = StSuspect;
              run_d[i]   = 4'd1;
            end
          end
          StSuspect: begin
            if (run_q[i] + 4'd1 == PersistN) begin
              state_d[i] = StFaulty;
              run_d[i]   = '0;
              enter[i]   = 1'b1;
            end else begin
              run_d[i] = run_q[i] + 4'd1;
            end
          end
          default: ;
        endcase
      end else if (bus.in_valid && state_q[i] == StSuspect) begin
        state_d[i] = StOk;
        run_d[i]   = '0;
      end
    end
    flag_d = flag_q | enter;
    // clr wins over the sample presented in the same cycle
    if (bus.clr) begin
      flag_d = '0;
      for (int i = 0; i < 3; i++) begin
        state_d[i] = StOk;
        run_d[i]   = '0;
        cnt_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_q <= '0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= StOk;
        run_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      flag_q <= flag_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        run_q[i]   <= run_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.err_cnt_0  = cnt_q[0];
  assign bus.err_cnt_1  = cnt_q[1];
  assign bus.err_cnt_2  = cnt_q[2];
  assign bus.fault_flag = flag_q;

`ifdef TMR_MON_REPORT_EN
  logic [2:0] pend_q;
  logic [2:0] pend_d;
  logic       lock_q;
  logic       lock_d;
  logic [1:0] idx_q;
  logic [1:0] idx_d;
  logic [1:0] idx_low;
  logic [1:0] idx_cur;
  logic       rpt_valid;
  logic       ack;

  always_comb begin
    idx_low = 2'd0;
    if (pend_q[0])      idx_low = 2'd0;
    else if (pend_q[1]) idx_low = 2'd1;
    else if (pend_q[2]) idx_low = 2'd2;
  end

  // Once offered, the index stays put until accepted, even if a lower one arrives
  assign idx_cur   = lock_q ? idx_q : idx_low;
  assign rpt_valid = |pend_q;
  assign ack       = rpt_valid & bus.rpt_ready;

  always_comb begin
    pend_d = (pend_q & ~(ack ? (3'b001 << idx_cur) : 3'b000)) | enter;
    lock_d = rpt_valid & ~bus.rpt_ready;
    idx_d  = idx_cur;
    if (bus.clr) begin
      pend_d = '0;
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      lock_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      pend_q <= pend_d;
      lock_q <= lock_d;
      idx_q  <= idx_d;
    end
  end

  assign bus.rpt_valid = rpt_valid;
  assign bus.rpt_idx   = idx_cur;
`else
  logic unused_rpt;
  assign unused_rpt    = ^{bus.rpt_ready, enter};
  assign bus.rpt_valid = 1'b0;
  assign bus.rpt_idx   = 2'd0;
`endif

endmodule

// File: tb/tb_tmr_mismatch_monitor.sv
// Self-checking bench for tmr_mismatch_monitor (WIDTH=2, CNT_W=2, PERSIST=3), with a scoreboard
// for the voted path and an expected-report queue; adapts to TMR_MON_REPORT_EN.
module tb_tmr_mismatch_monitor;

  localparam int unsigned WIDTH   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned PERSIST = 3;
`ifdef TMR_MON_REPORT_EN
  localparam bit REPORT_EN = 1'b1;
`else
  localparam bit REPORT_EN = 1'b0;
`endif
  localparam logic [1:0] G = 2'b11;

  typedef struct packed {
    logic [1:0] voted;
    logic [2:0] mis;
    logic       uncorr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   rpt_seen;
  exp_t exp_q[$];
  int   exp_rpt[$];
  exp_t mon_e;

  tmr_mismatch_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  tmr_mismatch_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PERSIST(PERSIST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    exp_t e;
    int   n_mis;
    for (int k = 0; k < 2; k++) begin
      e.voted[k] = (int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2;
    end
    e.mis    = {c != e.voted, b != e.voted, a != e.voted};
    n_mis    = int'(e.mis[0]) + int'(e.mis[1]) + int'(e.mis[2]);
    e.uncorr = n_mis >= 2;
    return e;
  endfunction

  task automatic step(input logic v, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input logic cl);
    @(negedge clk);
    bus.in_valid = v;
    bus.rep_0    = a;
    bus.rep_1    = b;
    bus.rep_2    = c;
    bus.clr      = cl;
    if (v) exp_q.push_back(model(a, b, c));
  endtask

  task automatic idle();
    step(1'b0, G, G, G, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow_out_valid", bus.out_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_voted", bus.voted_out, mon_e.voted);
        check_eq("sb_mis_vec", bus.mis_vec, mon_e.mis);
        check_eq("sb_uncorr", bus.uncorr, mon_e.uncorr);
      end
    end
    if (bus.rpt_valid === 1'b1) rpt_seen = 1'b1;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && bus.rpt_valid === 1'b1 && bus.rpt_ready === 1'b1) begin
      if (exp_rpt.size() == 0) check_eq("rpt_unexpected_valid", bus.rpt_valid, 0);
      else check_eq("rpt_hs_idx", bus.rpt_idx, exp_rpt.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    checks       = 0;
    failures     = 0;
    rpt_seen     = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.rep_0    = '0;
    bus.rep_1    = '0;
    bus.rep_2    = '0;
    bus.clr      = 1'b0;
    bus.rpt_ready = 1'b0;

    // Reset values
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_voted", bus.voted_out, 0);
      check_eq("rst_mis_vec", bus.mis_vec, 0);
      check_eq("rst_uncorr", bus.uncorr, 0);
      check_eq("rst_cnt0", bus.err_cnt_0, 0);
      check_eq("rst_cnt1", bus.err_cnt_1, 0);
      check_eq("rst_cnt2", bus.err_cnt_2, 0);
      check_eq("rst_flag", bus.fault_flag, 0);
      check_eq("rst_rpt_valid", bus.rpt_valid, 0);
      check_eq("rst_rpt_idx", bus.rpt_idx, 0);
    end
    rst_n = 1'b1;

    // Agreement
    repeat (10) step(1'b1, G, G, G, 1'b0);
    idle();
    check_eq("agree_cnt0", bus.err_cnt_0, 0);
    check_eq("agree_cnt1", bus.err_cnt_1, 0);
    check_eq("agree_cnt2", bus.err_cnt_2, 0);

    // Transient fault on rep_1
    rpt_seen = 1'b0;
    repeat (2) step(1'b1, G, G ^ 2'b01, G, 1'b0);
    step(1'b1, G, G, G, 1'b0);
    idle();
    check_eq("trans_cnt1", bus.err_cnt_1, 2);
    check_eq("trans_flag", bus.fault_flag, 3'b000);
    repeat (2) step(1'b1, G, G ^ 2'b01, G, 1'b0);
    idle();
    check_eq("trans_back_to_ok", bus.fault_flag, 3'b000);
    check_eq("trans_cnt1_sat", bus.err_cnt_1, 3);
    check_eq("trans_no_rpt", rpt_seen, 0);
    step(1'b0, G, G, G, 1'b1);
    idle();
    check_eq("clr_cnt1", bus.err_cnt_1, 0);

    // Persistent fault on rep_2, consumer stalls 4 cycles
    repeat (2) step(1'b1, G, G, G ^ 2'b01, 1'b0);
    step(1'b1, G, G, G ^ 2'b01, 1'b0);
    if (REPORT_EN) exp_rpt.push_back(2);
    repeat (4) begin
      idle();
      check_eq("pers_flag", bus.fault_flag, 3'b100);
      check_eq("pers_rpt_valid", bus.rpt_valid, REPORT_EN);
      check_eq("pers_rpt_idx", bus.rpt_idx, REPORT_EN ? 2 : 0);
    end
    @(negedge clk);
    bus.rpt_ready = 1'b1;
    @(negedge clk);
    bus.rpt_ready = 1'b0;
    check_eq("pers_rpt_cleared", bus.rpt_valid, 0);
    step(1'b0, G, G, G, 1'b1);
    idle();

    // Simultaneous faults, consumer always ready
    bus.rpt_ready = 1'b1;
    repeat (2) step(1'b1, 2'b10, 2'b01, G, 1'b0);
    step(1'b1, 2'b10, 2'b01, G, 1'b0);
    if (REPORT_EN) begin
      exp_rpt.push_back(0);
      exp_rpt.push_back(1);
    end
    idle();
    check_eq("sim_flag", bus.fault_flag, 3'b011);
    check_eq("sim_rpt_valid0", bus.rpt_valid, REPORT_EN);
    check_eq("sim_rpt_idx0", bus.rpt_idx, 0);
    idle();
    check_eq("sim_rpt_valid1", bus.rpt_valid, REPORT_EN);
    check_eq("sim_rpt_idx1", bus.rpt_idx, REPORT_EN ? 1 : 0);
    idle();
    check_eq("sim_rpt_done", bus.rpt_valid, 0);
    step(1'b0, G, G, G, 1'b1);

    // Saturation on rep_0
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, G ^ 2'b01, G, G, 1'b0);
      if (k == 3 && REPORT_EN) exp_rpt.push_back(0);
      idle();
      check_eq("sat_cnt0", bus.err_cnt_0, (k < 3) ? k : 3);
    end
    check_eq("sat_flag", bus.fault_flag, 3'b001);
    bus.rpt_ready = 1'b0;
    step(1'b0, G, G, G, 1'b1);

    // Offered index held while a lower index becomes pending
    repeat (3) step(1'b1, G, G, G ^ 2'b10, 1'b0);
    if (REPORT_EN) exp_rpt.push_back(2);
    repeat (3) step(1'b1, G ^ 2'b10, G, G, 1'b0);
    if (REPORT_EN) exp_rpt.push_back(0);
    idle();
    check_eq("hold_flag", bus.fault_flag, 3'b101);
    check_eq("hold_rpt_idx", bus.rpt_idx, REPORT_EN ? 2 : 0);
    bus.rpt_ready = 1'b1;
    @(negedge clk);
    check_eq("hold_next_valid", bus.rpt_valid, REPORT_EN);
    check_eq("hold_next_idx", bus.rpt_idx, 0);
    @(negedge clk);
    check_eq("hold_done", bus.rpt_valid, 0);
    bus.rpt_ready = 1'b0;
    step(1'b0, G, G, G, 1'b1);

    // clr collides with a mismatching sample while a report is pending
    repeat (3) step(1'b1, G, G ^ 2'b01, G, 1'b0);
    idle();
    check_eq("clrp_rpt_before", bus.rpt_valid, REPORT_EN);
    step(1'b1, G, G ^ 2'b01, G, 1'b1);
    idle();
    check_eq("clrp_cnt1", bus.err_cnt_1, 0);
    check_eq("clrp_flag", bus.fault_flag, 0);
    check_eq("clrp_rpt_valid", bus.rpt_valid, 0);
    check_eq("clrp_rpt_idx", bus.rpt_idx, 0);

    // Invalid samples are ignored
    step(1'b0, G ^ 2'b01, G, G, 1'b0);
    idle();
    check_eq("inval_out_valid", bus.out_valid, 0);
    check_eq("inval_cnt0", bus.err_cnt_0, 0);
    check_eq("inval_mis_vec", bus.mis_vec, 0);

    repeat (2) idle();
    check_eq("sb_drain", exp_q.size(), 0);
    check_eq("rpt_drain", exp_rpt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
